execute_stage: RTL
==================

# execute_stage

Pipeline execute stage of the five-stage RV32 core, sitting directly upstream of `storeStage` and driving its `RegWrite`/`ResultSrc`/`MemWrite`/`Rdm`/`ALUResultm`/`regdata`/`immext` inputs. It resolves operand forwarding, computes single-cycle ALU results, and runs an iterative 32-cycle unsigned multiply/divide unit that stalls the front end. It contains the EX/MEM pipeline register.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.
- `MD_CYCLES`, 32, number of iterations for MUL/DIV; fixed at `XLEN`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_e`  in  1  ID/EX holds a real instruction.
- `flush_e`  in  1  kill the instruction in EX, including an in-flight MUL/DIV.
- `RegWritee`, `MemWritee`  in  1 each  control from ID/EX.
- `ResultSrce`  in  2  writeback select, passed through unchanged.
- `ALUControle`  in  4  operation code (see Operation).
- `ALUSrce`  in  1  1 selects `immexte` as SrcB.
- `Rde`  in  5  destination register.
- `rd1e`, `rd2e`, `immexte`, `pcplus4e`  in  32 each  operands, immediate, and PC+4.
- `ForwardAe`, `ForwardBe`  in  2 each  forward select from the hazard unit.
- `ResultW`  in  32  writeback result used for forwarding.
- `stall_ex`  out  1  hold IF/ID and ID/EX.
- `RegWritem`, `MemWritem`  out  1 each  registered control.
- `ResultSrcm`  out  2  registered control.
- `Rdm`  out  5  registered destination register.
- `ALUResultm`, `WriteDatam`, `immextm`, `pcplus4m`  out  32 each  registered data.

## Operation
- Forwarding applies to both operands. Select 00 takes `rd1e`/`rd2e`, 01 takes `ResultW`, 10 takes `ALUResultm` (this stage's registered output), and 11 is treated as 00.
- SrcA is forwarded A. SrcB is `ALUSrce ? immexte : forwarded B`. `WriteDatam` always captures forwarded B.
- Single-cycle ALUControl codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA. Shift amount is SrcB[4:0].
- Multi-cycle ALUControl codes: 1010 MUL (low 32 bits), 1011 MULHU (high 32 bits of the unsigned product), 1100 DIVU, 1101 REMU. Codes 1110 and 1111 produce 0.
- All arithmetic is modulo 2^32 with no overflow flag.
- DIVU by zero gives 0xFFFFFFFF. REMU by zero gives the dividend. The restoring algorithm must produce both results naturally, with no special case.
- The MUL/DIV state machine has three states:
  - IDLE: if `valid_e` is high, a multi-cycle op is present, and `flush_e` is low, latch SrcA, SrcB and the op, clear the counter, and go to BUSY.
  - BUSY: perform one shift-add or shift-subtract iteration per cycle. When counter = 31, go to DONE.
  - DONE: present the result and go to IDLE.
- `stall_ex` is 1 in the IDLE-accept cycle and in BUSY, and 0 in DONE and at all other times (combinational).
- EX/MEM register loads, on every edge:
  - `flush_e` = 1, or `stall_ex` = 1: a bubble, meaning all outputs are 0 and in particular `RegWritem` = `MemWritem` = 0.
  - otherwise, if `valid_e` = 0: a bubble.
  - otherwise, single-cycle op: the ALU result and passed-through fields.
  - otherwise, DONE: the MUL/DIV result plus the ID/EX fields, which are held stable by the stall.
- `flush_e` in BUSY or DONE returns the state machine to IDLE with no result and a bubble into EX/MEM.

## Timing
- Reset (`reset` = 0) sets every EX/MEM output to 0 and the state machine to IDLE. `stall_ex` = 0 while in reset. An in-flight op is discarded.
- Single-cycle op: result is visible at EX/MEM one edge after presentation. No stall.
- MUL/DIV, with presentation at cycle 0:
  - `stall_ex` is high for cycles 0–32 (33 cycles).
  - DONE is at cycle 33.
  - The result appears on `ALUResultm` after the edge ending cycle 33, i.e. 34 cycles of latency.
  - 33 bubbles precede it.
- Back-to-back MUL/DIV: the second op is accepted in the cycle after DONE. No overlap.
- Forwarded operands are sampled only in the accept cycle. Later changes on `ResultW` or `ALUResultm` do not affect the op in flight.

## Structure
- Package `rv_pkg` holds:
  - ALUControl codes.
  - ResultSrc codes: 00 ALU, 01 memory, 10 PC+4, 11 immediate.
  - Forward-select codes.
  - The MUL/DIV state enum (IDLE, BUSY, DONE).
- One sub-module, `muldiv_iter`, contains the state machine, counter, and shift registers. Its handshake is `start`/`op`/`a`/`b`/`flush` in and `busy`/`done`/`result` out.
- The top level contains forwarding, the ALU, and the EX/MEM register.

## Test plan
- ADD, forwarding bypassed: `rd1e` = 5, `rd2e` = 7, ALUControl 0000, Rde = 3 → next edge `ALUResultm` = 12, `Rdm` = 3, `RegWritem` = 1, `stall_ex` never asserted.
- Forwarding: `ForwardAe` = 10 with the previous ALUResultm = 0x100, `ForwardBe` = 01 with `ResultW` = 0x20, SUB → 0xE0. `ALUSrce` = 1 with `immexte` = 0xFFFFFFFC, ADD → 0xFC.
- MUL: 0x0001_0000 × 0x0001_0000 → MUL gives 0, MULHU gives 1. `stall_ex` is high for exactly 33 cycles, and the result lands at cycle 34.
- DIVU/REMU: 100 / 7 gives 14 and 2. Divide by 0 gives 0xFFFFFFFF and 100. 0xFFFFFFFF / 1 gives 0xFFFFFFFF.
- Flush mid-op: DIVU, then `flush_e` at cycle 10 → `stall_ex` drops next cycle, no write into EX/MEM (`RegWritem` stays 0), and a following ADD completes normally.
- Reset mid-op: assert `reset` low during BUSY → all outputs 0 immediately, state IDLE. After release, MUL 3×4 returns 12 with the full 34-cycle latency.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared encodings for the RV32 execute stage: ALU op codes, writeback and
// forward selects, the MUL/DIV state enum and the EX/MEM register layout.
package rv_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'b0000,
      ALU_SUB   = 4'b0001,
      ALU_AND   = 4'b0010,
      ALU_OR    = 4'b0011,
      ALU_XOR   = 4'b0100,
      ALU_SLT   = 4'b0101,
      ALU_SLTU  = 4'b0110,
      ALU_SLL   = 4'b0111,
      ALU_SRL   = 4'b1000,
      ALU_SRA   = 4'b1001,
      ALU_MUL   = 4'b1010,
      ALU_MULHU = 4'b1011,
      ALU_DIVU  = 4'b1100,
      ALU_REMU  = 4'b1101,
      ALU_RSV0  = 4'b1110,
      ALU_RSV1  = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10,
      RES_IMM = 2'b11
   } result_src_e;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10,
      FWD_RSV  = 2'b11
   } fwd_sel_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_BUSY = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   typedef struct packed {
      logic        reg_write;
      logic        mem_write;
      logic [1:0]  result_src;
      logic [4:0]  rd;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] imm_ext;
      logic [31:0] pc_plus4;
   } ex_mem_t;

   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage; master is the
// upstream pipeline side, slave is the execute stage itself.
interface execute_stage_if #(parameter int XLEN = 32);
   logic            valid_e;
   logic            flush_e;
   logic            RegWritee;
   logic            MemWritee;
   logic [1:0]      ResultSrce;
   logic [3:0]      ALUControle;
   logic            ALUSrce;
   logic [4:0]      Rde;
   logic [XLEN-1:0] rd1e;
   logic [XLEN-1:0] rd2e;
   logic [XLEN-1:0] immexte;
   logic [XLEN-1:0] pcplus4e;
   logic [1:0]      ForwardAe;
   logic [1:0]      ForwardBe;
   logic [XLEN-1:0] ResultW;

   logic            stall_ex;
   logic            RegWritem;
   logic            MemWritem;
   logic [1:0]      ResultSrcm;
   logic [4:0]      Rdm;
   logic [XLEN-1:0] ALUResultm;
   logic [XLEN-1:0] WriteDatam;
   logic [XLEN-1:0] immextm;
   logic [XLEN-1:0] pcplus4m;

   modport master (
      output valid_e, flush_e, RegWritee, MemWritee, ResultSrce, ALUControle, ALUSrce,
             Rde, rd1e, rd2e, immexte, pcplus4e, ForwardAe, ForwardBe, ResultW,
      input  stall_ex, RegWritem, MemWritem, ResultSrcm, Rdm, ALUResultm, WriteDatam,
             immextm, pcplus4m
   );

   modport slave (
      input  valid_e, flush_e, RegWritee, MemWritee, ResultSrce, ALUControle, ALUSrce,
             Rde, rd1e, rd2e, immexte, pcplus4e, ForwardAe, ForwardBe, ResultW,
      output stall_ex, RegWritem, MemWritem, ResultSrcm, Rdm, ALUResultm, WriteDatam,
             immextm, pcplus4m
   );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
//   state   | meaning
//   MD_IDLE | waiting for start; on start latch operands and op, load counter
//   MD_BUSY | one shift-add / shift-subtract per cycle, counter runs down to 0
//   MD_DONE | result valid for one cycle, then back to idle
module muldiv_iter
   import rv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(MD_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);

   md_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [3:0]      op_q, op_d;

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_rem;
   logic            is_mul;

   // hi holds the partial product / remainder, lo the multiplier / quotient.
   assign is_mul    = (op_q == ALU_MUL) || (op_q == ALU_MULHU);
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
   assign div_shift = {hi_q, lo_q[XLEN-1]};
   assign div_ge    = div_shift >= {1'b0, b_q};
   assign div_rem   = div_shift[XLEN-1:0] - b_q;
   assign result    = ((op_q == ALU_MULHU) || (op_q == ALU_REMU)) ? hi_q : lo_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      op_d    = op_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         MD_IDLE: begin
            if (start) begin
               busy    = 1'b1;
               state_d = MD_BUSY;
               cnt_d   = CNT_LAST;
               hi_d    = '0;
               lo_d    = a;
               b_d     = b;
               op_d    = op;
            end
         end
         MD_BUSY: begin
            busy = 1'b1;
            if (is_mul) begin
               hi_d = mul_sum[XLEN:1];
               lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
            end else if (div_ge) begin
               hi_d = div_rem;
               lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
               hi_d = div_shift[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q == '0) state_d = MD_DONE;
            else             cnt_d   = cnt_q - 1'b1;
            if (flush) state_d = MD_IDLE;
         end
         MD_DONE: begin
            done    = ~flush;
            state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         op_q    <= op_d;
      end
   end

endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: operand forwarding, single-cycle ALU, iterative MUL/DIV
// with front-end stall, and the EX/MEM pipeline register.
module execute_stage
   import rv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int MD_CYCLES = XLEN
) (
   input logic            clk,
   input logic            reset,
   execute_stage_if.slave ex
);

   ex_mem_t         exmem_q, exmem_d;
   logic [XLEN-1:0] fwd_a, fwd_b, src_b;
   logic [XLEN-1:0] alu_out;
   logic [XLEN-1:0] md_result;
   logic            md_op, md_start, md_busy, md_done;
   logic            load_ok;

   always_comb begin
      case (ex.ForwardAe)
         FWD_WB:  fwd_a = ex.ResultW;
         FWD_MEM: fwd_a = exmem_q.alu_result;
         default: fwd_a = ex.rd1e;
      endcase
      case (ex.ForwardBe)
         FWD_WB:  fwd_b = ex.ResultW;
         FWD_MEM: fwd_b = exmem_q.alu_result;
         default: fwd_b = ex.rd2e;
      endcase
   end

   assign src_b = ex.ALUSrce ? ex.immexte : fwd_b;

   always_comb begin
      alu_out = '0;
      case (ex.ALUControle)
         ALU_ADD:  alu_out = fwd_a + src_b;
         ALU_SUB:  alu_out = fwd_a - src_b;
         ALU_AND:  alu_out = fwd_a & src_b;
         ALU_OR:   alu_out = fwd_a | src_b;
         ALU_XOR:  alu_out = fwd_a ^ src_b;
         ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(src_b)};
         ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, fwd_a < src_b};
         ALU_SLL:  alu_out = fwd_a << src_b[4:0];
         ALU_SRL:  alu_out = fwd_a >> src_b[4:0];
         ALU_SRA:  alu_out = $signed(fwd_a) >>> src_b[4:0];
         default:  alu_out = '0;
      endcase
   end

   assign md_op    = is_muldiv(ex.ALUControle);
   assign md_start = ex.valid_e & md_op & ~ex.flush_e;

   muldiv_iter #(
      .XLEN      (XLEN),
      .MD_CYCLES (MD_CYCLES)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (md_start),
      .op     (ex.ALUControle),
      .a      (fwd_a),
      .b      (src_b),
      .flush  (ex.flush_e),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   // A multi-cycle op only reaches EX/MEM in its DONE cycle; otherwise a bubble.
   assign load_ok = ex.valid_e & ~ex.flush_e & ~md_busy & (~md_op | md_done);

   always_comb begin
      exmem_d = '0;
      if (load_ok) begin
         exmem_d.reg_write  = ex.RegWritee;
         exmem_d.mem_write  = ex.MemWritee;
         exmem_d.result_src = ex.ResultSrce;
         exmem_d.rd         = ex.Rde;
         exmem_d.alu_result = md_op ? md_result : alu_out;
         exmem_d.write_data = fwd_b;
         exmem_d.imm_ext    = ex.immexte;
         exmem_d.pc_plus4   = ex.pcplus4e;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) exmem_q <= '0;
      else        exmem_q <= exmem_d;
   end

   assign ex.stall_ex   = md_busy & reset;
   assign ex.RegWritem  = exmem_q.reg_write;
   assign ex.MemWritem  = exmem_q.mem_write;
   assign ex.ResultSrcm = exmem_q.result_src;
   assign ex.Rdm        = exmem_q.rd;
   assign ex.ALUResultm = exmem_q.alu_result;
   assign ex.WriteDatam = exmem_q.write_data;
   assign ex.immextm    = exmem_q.imm_ext;
   assign ex.pcplus4m   = exmem_q.pc_plus4;

endmodule
